// File: rtl/ddr_data_burst_if.sv
// Bus bundle for ddr_data_burst: rdy pulses, write FIFO port, DQ/DQS pins and read result.
interface ddr_data_burst_if #(
  parameter int unsigned DQ_WIDTH = 8,
  parameter int unsigned BL       = 8
);
  logic                   wr_rdy;
  logic                   rd_rdy;
  logic                   bc4;
  logic                   wr_push;
  logic [BL*DQ_WIDTH-1:0] wr_data;
  logic                   wr_full;
  logic [DQ_WIDTH-1:0]    dq_in;
  logic [DQ_WIDTH-1:0]    dq_out;
  logic                   dq_oe;
  logic                   dqs_t;
  logic                   dqs_c;
  logic                   dqs_oe;
  logic [BL*DQ_WIDTH-1:0] rd_data;
  logic                   rd_valid;
  logic                   data_idle;
  logic                   err;

  modport master (
    output wr_rdy, rd_rdy, bc4, wr_push, wr_data, dq_in,
    input  wr_full, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, rd_data, rd_valid, data_idle, err
  );

  modport slave (
    input  wr_rdy, rd_rdy, bc4, wr_push, wr_data, dq_in,
    output wr_full, dq_out, dq_oe, dqs_t, dqs_c, dqs_oe, rd_data, rd_valid, data_idle, err
  );
endinterface

// File: rtl/ddr_data_burst.sv
// DQ/DQS burst engine: write-data FIFO with preamble/burst/postamble, read beat assembly.
// Burst chop (4-beat bursts requested via bc4) is compiled in when BC4_EN is defined.
module ddr_data_burst #(
  parameter int unsigned DQ_WIDTH    = 8,
  parameter int unsigned BL          = 8,
  parameter int unsigned WR_PRE      = 1,
  parameter int unsigned RD_PRE      = 1,
  parameter int unsigned WFIFO_DEPTH = 4
) (
  input  logic            CK_t,
  input  logic            reset_n,
  ddr_data_burst_if.slave bus
);
  localparam int unsigned BW = $clog2(BL) + 1;
  localparam int unsigned AW = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int unsigned WW = BL * DQ_WIDTH;

  localparam logic [1:0]    WR_PRE_LAST = 2'(WR_PRE - 1);
  localparam logic [1:0]    RD_PRE_LAST = 2'(RD_PRE - 1);
  localparam logic [BW-1:0] LAST_FULL   = BW'(BL - 1);
  localparam logic [BW-1:0] LAST_BC4    = BW'(3);
  localparam logic [AW-1:0] PTR_LAST    = AW'(WFIFO_DEPTH - 1);
  localparam logic [AW:0]   CNT_FULL    = (AW + 1)'(WFIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST, S_POST} state_t;
  typedef enum logic {D_RD, D_WR} dir_t;

  state_t        r_state, w_state_nxt;
  dir_t          r_dir, w_dir_nxt;
  logic [1:0]    r_pre_cnt, w_pre_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic          r_bc4, w_bc4_nxt;
  logic          w_bc4_in;

  logic [WW-1:0] r_wbuf, w_wbuf_nxt;
  logic [WW-1:0] r_rd_cap, w_rd_cap;
  logic [WW-1:0] w_rd_word;

  logic [WW-1:0] r_fifo [WFIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          w_push, w_pop, w_pop_ok, w_empty;

  logic          w_same, w_opp, w_pre_last;
  logic [BW-1:0] w_beat_last;
  logic          w_err, w_rd_done;
  logic          w_dq_oe_nxt, w_dqs_oe_nxt, w_dqs_t_nxt;
  logic [DQ_WIDTH-1:0] w_slot;

  logic [DQ_WIDTH-1:0] r_dq_out;
  logic          r_dq_oe, r_dqs_t, r_dqs_c, r_dqs_oe;
  logic [WW-1:0] r_rd_data;
  logic          r_rd_valid, r_idle, r_err, r_full;

`ifdef BC4_EN
  assign w_bc4_in = bus.bc4;
`else
  logic w_unused_bc4;
  assign w_bc4_in     = 1'b0;
  assign w_unused_bc4 = bus.bc4;
`endif

  assign w_empty     = (r_count == '0);
  assign w_push      = bus.wr_push && !r_full;
  assign w_pop_ok    = w_pop && !w_empty;
  assign w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop_ok);

  assign w_same      = (r_dir == D_WR) ? bus.wr_rdy : bus.rd_rdy;
  assign w_opp       = (r_dir == D_WR) ? bus.rd_rdy : bus.wr_rdy;
  assign w_pre_last  = (r_dir == D_WR) ? (r_pre_cnt == WR_PRE_LAST) : (r_pre_cnt == RD_PRE_LAST);
  assign w_beat_last = r_bc4 ? LAST_BC4 : LAST_FULL;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_pre_nxt   = r_pre_cnt;
    w_beat_nxt  = r_beat;
    w_bc4_nxt   = r_bc4;
    w_pop       = 1'b0;
    w_err       = 1'b0;
    w_rd_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.wr_rdy) begin
          w_state_nxt = S_PRE;
          w_dir_nxt   = D_WR;
          w_pre_nxt   = '0;
          w_bc4_nxt   = w_bc4_in;
          w_pop       = 1'b1;
          w_err       = bus.rd_rdy;
        end else if (bus.rd_rdy) begin
          w_state_nxt = S_PRE;
          w_dir_nxt   = D_RD;
          w_pre_nxt   = '0;
          w_bc4_nxt   = w_bc4_in;
        end
      end
      S_PRE: begin
        w_err = bus.wr_rdy | bus.rd_rdy;
        if (w_pre_last) begin
          w_state_nxt = S_BURST;
          w_beat_nxt  = '0;
        end else begin
          w_pre_nxt = r_pre_cnt + 2'd1;
        end
      end
      S_BURST: begin
        if (r_beat == w_beat_last) begin
          w_rd_done = (r_dir == D_RD);
          w_err     = w_opp;
          // Same-direction rdy on the final beat chains straight into the next burst.
          if (w_same) begin
            w_beat_nxt = '0;
            w_bc4_nxt  = w_bc4_in;
            w_pop      = (r_dir == D_WR);
          end else begin
            w_state_nxt = S_POST;
          end
        end else begin
          w_beat_nxt = r_beat + BW'(1);
          w_err      = bus.wr_rdy | bus.rd_rdy;
        end
      end
      S_POST: begin
        w_err = w_opp;
        if (w_same) begin
          w_state_nxt = S_BURST;
          w_beat_nxt  = '0;
          w_bc4_nxt   = w_bc4_in;
          w_pop       = (r_dir == D_WR);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_pop && w_empty) w_err = 1'b1;
  end

  // Read capture, final word assembly and write beat selection.
  always_comb begin
    w_rd_cap   = r_rd_cap;
    w_wbuf_nxt = r_wbuf;
    w_slot     = '0;
    if (w_pop) w_wbuf_nxt = w_empty ? '0 : r_fifo[r_rptr];
    for (int unsigned k = 0; k < BL; k++) begin
      if (r_state == S_BURST && r_dir == D_RD && 32'(r_beat) == k)
        w_rd_cap[k*DQ_WIDTH +: DQ_WIDTH] = bus.dq_in;
    end
    w_rd_word = w_rd_cap;
    for (int unsigned k = 4; k < BL; k++) begin
      if (r_bc4) w_rd_word[k*DQ_WIDTH +: DQ_WIDTH] = '0;
    end
    for (int unsigned k = 0; k < BL; k++) begin
      if (32'(w_beat_nxt) == k) w_slot = w_wbuf_nxt[k*DQ_WIDTH +: DQ_WIDTH];
    end
  end

  // Pin values are derived from the next state so every output leaves a flop.
  assign w_dq_oe_nxt  = (w_state_nxt == S_BURST) && (w_dir_nxt == D_WR);
  assign w_dqs_oe_nxt = (w_state_nxt != S_IDLE) && (w_dir_nxt == D_WR);
  assign w_dqs_t_nxt  = w_dq_oe_nxt && !w_beat_nxt[0];

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_dir      <= D_RD;
      r_pre_cnt  <= '0;
      r_beat     <= '0;
      r_bc4      <= 1'b0;
      r_wbuf     <= '0;
      r_rd_cap   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_dqs_t    <= 1'b0;
      r_dqs_c    <= 1'b1;
      r_dqs_oe   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_idle     <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_pre_cnt  <= w_pre_nxt;
      r_beat     <= w_beat_nxt;
      r_bc4      <= w_bc4_nxt;
      r_wbuf     <= w_wbuf_nxt;
      r_rd_cap   <= w_rd_cap;
      if (w_push)   r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + AW'(1);
      if (w_pop_ok) r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CNT_FULL);
      r_dq_out   <= w_dq_oe_nxt ? w_slot : '0;
      r_dq_oe    <= w_dq_oe_nxt;
      r_dqs_t    <= w_dqs_t_nxt;
      r_dqs_c    <= ~w_dqs_t_nxt;
      r_dqs_oe   <= w_dqs_oe_nxt;
      if (w_rd_done) r_rd_data <= w_rd_word;
      r_rd_valid <= w_rd_done;
      r_idle     <= (w_state_nxt == S_IDLE);
      r_err      <= w_err;
    end
  end

  always_ff @(posedge CK_t) begin
    if (w_push) r_fifo[r_wptr] <= bus.wr_data;
  end

  assign bus.dq_out    = r_dq_out;
  assign bus.dq_oe     = r_dq_oe;
  assign bus.dqs_t     = r_dqs_t;
  assign bus.dqs_c     = r_dqs_c;
  assign bus.dqs_oe    = r_dqs_oe;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.data_idle = r_idle;
  assign bus.err       = r_err;
  assign bus.wr_full   = r_full;
endmodule

// File: tb/tb_ddr_data_burst.sv
// Directed bench for ddr_data_burst: write/read timing, seamless bursts, FIFO limits, errors, reset.
module tb_ddr_data_burst;
  localparam int unsigned DQW = 8;
  localparam int unsigned BLN = 8;
`ifdef BC4_EN
  localparam int unsigned EXPB = 4;
`else
  localparam int unsigned EXPB = 8;
`endif

  logic CK_t = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CK_t = ~CK_t;

  ddr_data_burst_if #(.DQ_WIDTH(DQW), .BL(BLN)) bus ();

  ddr_data_burst #(
    .DQ_WIDTH(DQW), .BL(BLN), .WR_PRE(1), .RD_PRE(1), .WFIFO_DEPTH(4)
  ) dut (
    .CK_t(CK_t), .reset_n(reset_n), .bus(bus)
  );

  function automatic logic [63:0] mkw(input logic [7:0] b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[k*8 +: 8] = b + 8'(k);
    return w;
  endfunction

  task automatic push(input logic [63:0] d);
    bus.wr_push = 1'b1;
    bus.wr_data = d;
    @(negedge CK_t);
    bus.wr_push = 1'b0;
  endtask

  task automatic pulse(input logic wr, input logic rd, input logic b4);
    bus.wr_rdy = wr;
    bus.rd_rdy = rd;
    bus.bc4    = b4;
    @(negedge CK_t);
    bus.wr_rdy = 1'b0;
    bus.rd_rdy = 1'b0;
    bus.bc4    = 1'b0;
  endtask

  // Runs one plain write and gathers the beats seen on dq_out plus the err flag of cycle N+1.
  task automatic run_write(output logic [63:0] word, output logic e);
    word = '0;
    pulse(1'b1, 1'b0, 1'b0);
    e = bus.err;
    for (int c = 1; c <= 11; c++) begin
      if (bus.dq_oe) word = {bus.dq_out, word[63:8]};
      @(negedge CK_t);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge CK_t);
    n_tests++;
    if ({bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.rd_valid, bus.err, bus.wr_full, bus.data_idle} !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL reset_flags got %b want %b", {bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.rd_valid, bus.err, bus.wr_full, bus.data_idle}, 8'b0001_0001);
    end
    n_tests++;
    if ({bus.dq_out, bus.rd_data} !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_data got dq_out=%h rd_data=%h want 0", bus.dq_out, bus.rd_data);
    end
    reset_n = 1'b1;
    @(negedge CK_t);
  endtask

  task automatic test_write();
    int oe_cnt = 0;
    int soe_cnt = 0;
    logic exp_oe, exp_soe, exp_t, exp_idle;
    logic [7:0] exp_dq;
    push(64'h07060504_03020100);
    pulse(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      exp_oe   = (c >= 2 && c <= 9);
      exp_soe  = (c >= 1 && c <= 10);
      exp_dq   = exp_oe ? 8'(c - 2) : 8'h00;
      exp_t    = exp_oe && ((c % 2) == 0);
      exp_idle = (c == 11);
      n_tests++;
      if ({bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.err, bus.data_idle, bus.dq_out} !==
          {exp_oe, exp_soe, exp_t, ~exp_t, 1'b0, exp_idle, exp_dq}) begin
        n_fail++;
        $display("FAIL write c=%0d got oe=%b soe=%b t=%b c=%b err=%b idle=%b dq=%h want %b %b %b %b 0 %b %h",
                 c, bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.err, bus.data_idle, bus.dq_out,
                 exp_oe, exp_soe, exp_t, ~exp_t, exp_idle, exp_dq);
      end
      oe_cnt  += int'(bus.dq_oe);
      soe_cnt += int'(bus.dqs_oe);
      @(negedge CK_t);
    end
    n_tests++;
    if (oe_cnt != 8 || soe_cnt != 10) begin
      n_fail++;
      $display("FAIL write_oe_len got dq_oe=%0d dqs_oe=%0d want 8 10", oe_cnt, soe_cnt);
    end
  endtask

  task automatic test_read();
    pulse(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_tests++;
      if ({bus.rd_valid, bus.dq_oe, bus.dqs_oe, bus.err} !== {(c == 10), 3'b000}) begin
        n_fail++;
        $display("FAIL read_ctl c=%0d got valid=%b oe=%b soe=%b err=%b want %b 0 0 0",
                 c, bus.rd_valid, bus.dq_oe, bus.dqs_oe, bus.err, (c == 10));
      end
      if (c == 9) begin
        n_tests++;
        if (bus.rd_data !== 64'h0) begin
          n_fail++;
          $display("FAIL read_hold got %h want %h", bus.rd_data, 64'h0);
        end
      end
      if (c >= 10) begin
        n_tests++;
        if (bus.rd_data !== 64'hA7A6A5A4_A3A2A1A0) begin
          n_fail++;
          $display("FAIL read_data c=%0d got %h want %h", c, bus.rd_data, 64'hA7A6A5A4_A3A2A1A0);
        end
      end
      bus.dq_in = (c >= 2 && c <= 9) ? 8'hA0 + 8'(c - 2) : 8'hEE;
      @(negedge CK_t);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_oe, exp_soe, exp_t;
    logic [7:0] exp_dq;
    push(64'h17161514_13121110);
    push(64'h27262524_23222120);
    pulse(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      exp_oe  = (c >= 2 && c <= 17);
      exp_soe = (c >= 1 && c <= 18);
      exp_t   = exp_oe && ((c % 2) == 0);
      exp_dq  = !exp_oe ? 8'h00 : (c <= 9) ? 8'h10 + 8'(c - 2) : 8'h20 + 8'(c - 10);
      n_tests++;
      if ({bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.err, bus.dq_out} !== {exp_oe, exp_soe, exp_t, 1'b0, exp_dq}) begin
        n_fail++;
        $display("FAIL b2b c=%0d got oe=%b soe=%b t=%b err=%b dq=%h want %b %b %b 0 %h",
                 c, bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.err, bus.dq_out, exp_oe, exp_soe, exp_t, exp_dq);
      end
      bus.wr_rdy = (c == 9);
      @(negedge CK_t);
    end
  endtask

  task automatic test_underrun_full();
    logic [63:0] w;
    logic e;
    pulse(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_tests++;
      if ({bus.err, bus.dq_oe, bus.dq_out} !== {(c == 1), (c >= 2 && c <= 9), 8'h00}) begin
        n_fail++;
        $display("FAIL underrun c=%0d got err=%b oe=%b dq=%h want %b %b 00",
                 c, bus.err, bus.dq_oe, bus.dq_out, (c == 1), (c >= 2 && c <= 9));
      end
      @(negedge CK_t);
    end
    for (int i = 0; i < 4; i++) push(mkw(8'h30 + 8'(i * 16)));
    n_tests++;
    if (bus.wr_full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_set got %b want 1", bus.wr_full);
    end
    push(mkw(8'h70));
    for (int i = 0; i < 4; i++) begin
      run_write(w, e);
      n_tests++;
      if ({e, w} !== {1'b0, mkw(8'h30 + 8'(i * 16))}) begin
        n_fail++;
        $display("FAIL full_pop%0d got err=%b data=%h want 0 %h", i, e, w, mkw(8'h30 + 8'(i * 16)));
      end
      if (i == 0) begin
        n_tests++;
        if (bus.wr_full !== 1'b0) begin
          n_fail++;
          $display("FAIL full_clear got %b want 0", bus.wr_full);
        end
      end
    end
    run_write(w, e);
    n_tests++;
    if ({e, w} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL full_drop got err=%b data=%h want 1 0", e, w);
    end
  endtask

  task automatic test_errors();
    logic [63:0] w;
    pulse(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      n_tests++;
      if ({bus.err, bus.rd_valid, bus.dq_oe, bus.dqs_oe} !== {(c == 2 || c == 5), (c == 10), 2'b00}) begin
        n_fail++;
        $display("FAIL err_rd c=%0d got err=%b valid=%b oe=%b soe=%b want %b %b 0 0",
                 c, bus.err, bus.rd_valid, bus.dq_oe, bus.dqs_oe, (c == 2 || c == 5), (c == 10));
      end
      if (c == 10) begin
        n_tests++;
        if (bus.rd_data !== mkw(8'hB0)) begin
          n_fail++;
          $display("FAIL err_rd_data got %h want %h", bus.rd_data, mkw(8'hB0));
        end
      end
      bus.rd_rdy = (c == 1);
      bus.wr_rdy = (c == 4);
      bus.dq_in  = (c >= 2 && c <= 9) ? 8'hB0 + 8'(c - 2) : 8'hEE;
      @(negedge CK_t);
    end
    bus.rd_rdy = 1'b0;
    bus.wr_rdy = 1'b0;
    push(mkw(8'hD0));
    pulse(1'b1, 1'b1, 1'b0);
    w = '0;
    for (int c = 1; c <= 11; c++) begin
      n_tests++;
      if ({bus.err, bus.rd_valid, bus.dq_oe} !== {(c == 1), 1'b0, (c >= 2 && c <= 9)}) begin
        n_fail++;
        $display("FAIL both_rdy c=%0d got err=%b valid=%b oe=%b want %b 0 %b",
                 c, bus.err, bus.rd_valid, bus.dq_oe, (c == 1), (c >= 2 && c <= 9));
      end
      if (bus.dq_oe) w = {bus.dq_out, w[63:8]};
      @(negedge CK_t);
    end
    n_tests++;
    if (w !== mkw(8'hD0)) begin
      n_fail++;
      $display("FAIL both_rdy_data got %h want %h", w, mkw(8'hD0));
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    logic e;
    push(mkw(8'h80));
    push(mkw(8'h90));
    pulse(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge CK_t);
    n_tests++;
    if ({bus.dq_oe, bus.dq_out} !== {1'b1, 8'h83}) begin
      n_fail++;
      $display("FAIL mid_beat3 got oe=%b dq=%h want 1 83", bus.dq_oe, bus.dq_out);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.err, bus.wr_full, bus.data_idle, bus.dq_out} !==
        {7'b0001_001, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset got oe=%b soe=%b t=%b c=%b err=%b full=%b idle=%b dq=%h want 0 0 0 1 0 0 1 00",
               bus.dq_oe, bus.dqs_oe, bus.dqs_t, bus.dqs_c, bus.err, bus.wr_full, bus.data_idle, bus.dq_out);
    end
    @(negedge CK_t);
    reset_n = 1'b1;
    @(negedge CK_t);
    run_write(w, e);
    n_tests++;
    if ({e, w} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL mid_flush got err=%b data=%h want 1 0", e, w);
    end
  endtask

  task automatic test_bc4();
    logic [63:0] exp_rd;
    logic exp_oe, exp_soe;
    exp_rd = (EXPB == 4) ? 64'h00000000_E3E2E1E0 : 64'hE7E6E5E4_E3E2E1E0;
    push(mkw(8'hC0));
    pulse(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      exp_oe  = (c >= 2 && c < 2 + int'(EXPB));
      exp_soe = (c >= 1 && c <= 2 + int'(EXPB));
      n_tests++;
      if ({bus.dq_oe, bus.dqs_oe, bus.dq_out} !== {exp_oe, exp_soe, exp_oe ? 8'hC0 + 8'(c - 2) : 8'h00}) begin
        n_fail++;
        $display("FAIL bc4_wr c=%0d got oe=%b soe=%b dq=%h want %b %b", c, bus.dq_oe, bus.dqs_oe, bus.dq_out, exp_oe, exp_soe);
      end
      @(negedge CK_t);
    end
    pulse(1'b0, 1'b1, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      n_tests++;
      if (bus.rd_valid !== (c == 2 + int'(EXPB))) begin
        n_fail++;
        $display("FAIL bc4_rd_valid c=%0d got %b want %b", c, bus.rd_valid, (c == 2 + int'(EXPB)));
      end
      if (c == 2 + int'(EXPB)) begin
        n_tests++;
        if (bus.rd_data !== exp_rd) begin
          n_fail++;
          $display("FAIL bc4_rd_data got %h want %h", bus.rd_data, exp_rd);
        end
      end
      bus.dq_in = (c >= 2 && c <= 9) ? 8'hE0 + 8'(c - 2) : 8'hEE;
      @(negedge CK_t);
    end
  endtask

  initial begin
    bus.wr_rdy  = 1'b0;
    bus.rd_rdy  = 1'b0;
    bus.bc4     = 1'b0;
    bus.wr_push = 1'b0;
    bus.wr_data = '0;
    bus.dq_in   = '0;
    @(negedge CK_t);
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_underrun_full();
    test_errors();
    test_reset_mid();
    test_bc4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout after 50000 time units");
    $fatal(1, "watchdog");
  end
endmodule
